window_buffer_param: RTL and testbench

WINDOW_BUFFER_PARAM -- requirements
Module: window_buffer_param

---
 rtl/window_buffer_param.sv | 174 +++++++++++++++++
 tb/tb_window_buffer_param.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/window_buffer_param.sv
// WIN x WIN pixel window: bottom-up raster fill, one-pixel shift with edge reload.
// Optional macro WINDOW_ZERO_FILL_EN adds a zero_fill input that zeroes the vacated edge instead of reloading it.
module window_buffer_param #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned WIN   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_read,
    input  logic                     start_shift,
    input  logic [1:0]               shift_direc,
`ifdef WINDOW_ZERO_FILL_EN
    input  logic                     zero_fill,
`endif
    input  logic                     data_valid,
    input  logic [PIX_W-1:0]         data_r,
    output logic                     read_done,
    output logic                     shift_done,
    output logic                     busy,
    output logic                     window_valid,
    output logic [WIN*WIN*PIX_W-1:0] window_out
);

    localparam int unsigned NPIX  = WIN * WIN;
    localparam int unsigned CNT_W = $clog2(NPIX + 1);
    localparam int unsigned POS_W = $clog2(WIN);
    localparam int unsigned IDX_W = $clog2(NPIX);

    typedef enum logic [1:0] {IDLE, FILL, LOAD_EDGE, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [POS_W-1:0] row;
    logic [POS_W-1:0] col;
    logic             edge_row;
    logic [PIX_W-1:0] pix     [NPIX];
    logic [PIX_W-1:0] shifted [NPIX];
    logic [IDX_W-1:0] wr_idx;
    logic             zf;

    logic             fill_start;
    logic             shift_go;
    logic             capture;
    logic             fill_last;
    logic             edge_last;
    logic             read_done_d;
    logic             shift_done_d;
    logic             busy_d;

`ifdef WINDOW_ZERO_FILL_EN
    assign zf = zero_fill;
`else
    assign zf = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; start_read wins over start_shift
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_read)                      state_next = FILL;
                else if (start_shift && window_valid) state_next = zf ? DONE : LOAD_EDGE;
            end
            FILL:      if (data_valid && cnt == CNT_W'(NPIX - 1)) state_next = DONE;
            LOAD_EDGE: if (data_valid && cnt == CNT_W'(WIN - 1))  state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Output / datapath control decode
    always_comb begin
        fill_start   = 1'b0;
        shift_go     = 1'b0;
        capture      = 1'b0;
        fill_last    = 1'b0;
        edge_last    = 1'b0;
        fill_start   = (state == IDLE) && start_read;
        shift_go     = (state == IDLE) && !start_read && start_shift && window_valid;
        capture      = ((state == FILL) || (state == LOAD_EDGE)) && data_valid;
        fill_last    = (state == FILL) && data_valid && (cnt == CNT_W'(NPIX - 1));
        edge_last    = (state == LOAD_EDGE) && data_valid && (cnt == CNT_W'(WIN - 1));
        read_done_d  = fill_last;
        shift_done_d = edge_last || (shift_go && zf);
        busy_d       = (state_next != IDLE);
    end

    // Counter, write position and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            row          <= '0;
            col          <= '0;
            edge_row     <= 1'b0;
            read_done    <= 1'b0;
            shift_done   <= 1'b0;
            busy         <= 1'b0;
            window_valid <= 1'b0;
        end else begin
            read_done  <= read_done_d;
            shift_done <= shift_done_d;
            busy       <= busy_d;
            if (fill_start) begin
                window_valid <= 1'b0;
                cnt          <= '0;
                row          <= POS_W'(WIN - 1);
                col          <= '0;
            end else if (shift_go) begin
                cnt      <= '0;
                edge_row <= shift_direc[1];
                case (shift_direc)
                    2'b00:   begin row <= '0;               col <= POS_W'(WIN - 1); end
                    2'b10:   begin row <= POS_W'(WIN - 1); col <= '0;              end
                    default: begin row <= '0;               col <= '0;              end
                endcase
            end else if (capture) begin
                cnt <= cnt + CNT_W'(1);
                if (state == FILL) begin
                    if (col == POS_W'(WIN - 1)) begin
                        col <= '0;
                        row <= row - POS_W'(1);
                    end else begin
                        col <= col + POS_W'(1);
                    end
                end else if (edge_row) begin
                    col <= col + POS_W'(1);
                end else begin
                    row <= row + POS_W'(1);
                end
            end
            if (fill_last) window_valid <= 1'b1;
        end
    end

    assign wr_idx = IDX_W'(row) * IDX_W'(WIN) + IDX_W'(col);

    // Shifted image; the vacated edge reads as zero until reloaded
    always_comb begin
        for (int unsigned r = 0; r < WIN; r++) begin
            for (int unsigned c = 0; c < WIN; c++) begin
                shifted[IDX_W'(r*WIN + c)] = '0;
                case (shift_direc)
                    2'b00: if (c < WIN - 1) shifted[IDX_W'(r*WIN + c)] = pix[IDX_W'(r*WIN + c + 1)];
                    2'b01: if (c > 0)       shifted[IDX_W'(r*WIN + c)] = pix[IDX_W'(r*WIN + c - 1)];
                    2'b10: if (r < WIN - 1) shifted[IDX_W'(r*WIN + c)] = pix[IDX_W'((r + 1)*WIN + c)];
                    default: if (r > 0)     shifted[IDX_W'(r*WIN + c)] = pix[IDX_W'((r - 1)*WIN + c)];
                endcase
            end
        end
    end

    // Pixel storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NPIX; i++) pix[IDX_W'(i)] <= '0;
        end else if (shift_go) begin
            for (int unsigned i = 0; i < NPIX; i++) pix[IDX_W'(i)] <= shifted[IDX_W'(i)];
        end else if (capture) begin
            pix[wr_idx] <= data_r;
        end
    end

    for (genvar i = 0; i < NPIX; i++) begin : g_out
        assign window_out[i*PIX_W +: PIX_W] = pix[i];
    end

endmodule

// File: tb/tb_window_buffer_param.sv
// Directed bench for window_buffer_param at WIN=3, PIX_W=8; define WINDOW_ZERO_FILL_EN to also cover zero_fill.
module tb_window_buffer_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_read = 1'b0;
    logic        start_shift = 1'b0;
    logic [1:0]  shift_direc = 2'b00;
`ifdef WINDOW_ZERO_FILL_EN
    logic        zero_fill = 1'b0;
`endif
    logic        data_valid = 1'b0;
    logic [7:0]  data_r = 8'd0;
    logic        read_done;
    logic        shift_done;
    logic        busy;
    logic        window_valid;
    logic [71:0] window_out;

    int n_vec = 0;
    int n_err = 0;
    int exp_px [9];
    int fill_seq [9] = '{6, 7, 8, 3, 4, 5, 0, 1, 2};

    window_buffer_param #(.PIX_W(8), .WIN(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_read   (start_read),
        .start_shift  (start_shift),
        .shift_direc  (shift_direc),
`ifdef WINDOW_ZERO_FILL_EN
        .zero_fill    (zero_fill),
`endif
        .data_valid   (data_valid),
        .data_r       (data_r),
        .read_done    (read_done),
        .shift_done   (shift_done),
        .busy         (busy),
        .window_valid (window_valid),
        .window_out   (window_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_win(input string tag);
        for (int i = 0; i < 9; i++)
            chk($sformatf("%s_px%0d", tag, i), 32'(window_out[i*8 +: 8]), 32'(exp_px[i]));
    endtask

    task automatic feed(input int v);
        data_valid = 1'b1;
        data_r     = 8'(v);
        tick();
        data_valid = 1'b0;
    endtask

    // Full fill with the canonical sequence; optionally also raise start_shift
    task automatic do_fill(input string tag, input logic also_shift);
        start_read  = 1'b1;
        start_shift = also_shift;
        tick();
        start_read  = 1'b0;
        start_shift = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_wv_clr"}, 32'(window_valid), 32'd0);
        for (int k = 0; k < 9; k++) begin
            feed(fill_seq[k]);
            chk($sformatf("%s_rd%0d", tag, k), 32'(read_done), (k == 8) ? 32'd1 : 32'd0);
            chk($sformatf("%s_sd%0d", tag, k), 32'(shift_done), 32'd0);
        end
        chk({tag, "_wv"}, 32'(window_valid), 32'd1);
        tick();
        chk({tag, "_rd_end"}, 32'(read_done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        exp_px = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
        chk_win(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        logic got;

        // Reset state
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wv", 32'(window_valid), 32'd0);
        chk("rst_rd", 32'(read_done), 32'd0);
        chk("rst_sd", 32'(shift_done), 32'd0);
        chk("rst_win", window_out[31:0], 32'd0);
        rst = 1'b0;

        // Shift before any fill is ignored
        start_shift = 1'b1;
        tick();
        start_shift = 1'b0;
        chk("noshift_busy", 32'(busy), 32'd0);
        tick();
        chk("noshift_sd", 32'(shift_done), 32'd0);

        do_fill("fill1", 1'b0);

        // data_valid in IDLE is ignored
        feed(99);
        tick();
        chk_win("idle_dv");

        // Shift left, reload right column
        shift_direc = 2'b00;
        start_shift = 1'b1;
        tick();
        start_shift = 1'b0;
        chk("sl_busy", 32'(busy), 32'd1);
        feed(9);
        feed(10);
        chk("sl_sd_early", 32'(shift_done), 32'd0);
        feed(11);
        chk("sl_sd", 32'(shift_done), 32'd1);
        chk("sl_rd", 32'(read_done), 32'd0);
        tick();
        chk("sl_sd_end", 32'(shift_done), 32'd0);
        exp_px = '{1, 2, 9, 4, 5, 10, 7, 8, 11};
        chk_win("sl");

        // Both starts high: fill takes priority
        do_fill("prio", 1'b1);

        // Shift down, reload top row
        shift_direc = 2'b11;
        start_shift = 1'b1;
        tick();
        start_shift = 1'b0;
        feed(20);
        feed(21);
        feed(22);
        chk("sd_sd", 32'(shift_done), 32'd1);
        tick();
        exp_px = '{20, 21, 22, 0, 1, 2, 3, 4, 5};
        chk_win("sdn");

        // Fill with data_valid toggling (low first); stray start_read mid-fill ignored
        start_read = 1'b1;
        tick();
        start_read = 1'b0;
        n = 0;
        k = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            n++;
            data_valid = (n % 2 == 0);
            if (data_valid && k < 9) begin
                data_r = 8'(fill_seq[k]);
                k++;
            end
            start_read = (n == 6);
            tick();
            if (read_done) got = 1'b1;
        end
        data_valid = 1'b0;
        start_read = 1'b0;
        chk("tog_latency", 32'(n), 32'd18);
        tick();
        exp_px = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
        chk_win("tog");

        // Reset after 4 captured pixels, asynchronously mid-cycle
        start_read = 1'b1;
        tick();
        start_read = 1'b0;
        for (int i = 0; i < 4; i++) feed(fill_seq[i]);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_wv", 32'(window_valid), 32'd0);
        chk("arst_rd", 32'(read_done), 32'd0);
        chk("arst_sd", 32'(shift_done), 32'd0);
        exp_px = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        chk_win("arst");
        tick();
        rst = 1'b0;
        shift_direc = 2'b00;
        start_shift = 1'b1;
        tick();
        start_shift = 1'b0;
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_sd", 32'(shift_done), 32'd0);
        tick();
        chk("post_rst_sd2", 32'(shift_done), 32'd0);

`ifdef WINDOW_ZERO_FILL_EN
        // Shift right with zero fill: no pixels consumed
        do_fill("zf_fill", 1'b0);
        shift_direc = 2'b01;
        zero_fill   = 1'b1;
        start_shift = 1'b1;
        tick();
        start_shift = 1'b0;
        zero_fill   = 1'b0;
        chk("zf_sd", 32'(shift_done), 32'd1);
        exp_px = '{0, 0, 1, 0, 3, 4, 0, 6, 7};
        chk_win("zf");
        tick();
        chk("zf_sd_end", 32'(shift_done), 32'd0);
        chk("zf_idle", 32'(busy), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
